data_memory_responder: RTL and testbench

//  Responder end of the processor data-memory request interface: accepts one load/store request at a time, then

---
 rtl/mips_mem_pkg.sv | 36 +++
 rtl/mem_wait_counter.sv | 27 ++
 rtl/data_memory_responder.sv | 143 ++++++++++++++
 tb/tb_data_memory_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types, widths and helpers for the data-memory responder.
package mips_mem_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LAT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [WORD_BYTES-1:0] be;
  } mem_req_t;

  // Misaligned or beyond the array: such accesses never touch memory.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (addr >= ADDR_W'(WORD_BYTES * depth));
  endfunction

  function automatic logic [DATA_W-1:0] lane_mask(input logic [WORD_BYTES-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(WORD_BYTES); i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter: cleared on load, advances while enabled, flags when the limit is reached.
module mem_wait_counter
  import mips_mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [LAT_W-1:0] limit,
  output logic             done_c
);

  logic [LAT_W-1:0] count;

  assign done_c = enable && (count == limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && !done_c) begin
      count <= count + LAT_W'(1);
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: one outstanding load/store, programmable wait states, word array.
// Build option DMEM_BYTE_LANES_EN adds the req_be port and per-lane store enables.
module data_memory_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_LANES_EN
  input  logic [WORD_BYTES-1:0] req_be,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t                state, state_next;
  mem_req_t              req_q, req_next, incoming, cur;
  logic                  ready_next, valid_next, err_next;
  logic [DATA_W-1:0]     rdata_next;
  logic                  accept, commit, done_c, cur_err, mem_we;
  logic [IDX_W-1:0]      cur_idx;
  logic [DATA_W-1:0]     mem_wdata, cur_mask;
  logic [WORD_BYTES-1:0] be_in;
  logic [DATA_W-1:0]     mem [DEPTH];

`ifdef DMEM_BYTE_LANES_EN
  assign be_in = req_be;
`else
  assign be_in = {WORD_BYTES{1'b1}};
`endif

  assign accept   = (state == IDLE) && req_valid && req_ready;
  assign incoming = '{write: req_write, addr: req_addr, wdata: req_wdata, be: be_in};

  mem_wait_counter u_wait (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .enable (state == WAIT),
    .limit  (LAT_W'(LATENCY)),
    .done_c (done_c)
  );

  // Next state, next registered outputs and the commit of the pending access.
  always_comb begin
    state_next = state;
    req_next   = req_q;
    ready_next = req_ready;
    valid_next = rsp_valid;
    rdata_next = rsp_rdata;
    err_next   = rsp_err;
    commit     = 1'b0;
    cur        = req_q;
    mem_we     = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          req_next   = incoming;
          ready_next = 1'b0;
          if (LATENCY == 0) begin
            cur        = incoming;
            commit     = 1'b1;
            state_next = RESP;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (done_c) begin
          commit     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
          ready_next = 1'b1;
          valid_next = 1'b0;
          rdata_next = '0;
          err_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        ready_next = 1'b1;
        valid_next = 1'b0;
        rdata_next = '0;
        err_next   = 1'b0;
      end
    endcase

    cur_err   = addr_err(cur.addr, DEPTH);
    cur_idx   = cur.addr[IDX_W+1:2];
    cur_mask  = lane_mask(cur.be);
    mem_wdata = (mem[cur_idx] & ~cur_mask) | (cur.wdata & cur_mask);

    if (commit) begin
      valid_next = 1'b1;
      err_next   = cur_err;
      rdata_next = (!cur.write && !cur_err) ? mem[cur_idx] : '0;
      mem_we     = cur.write && !cur_err;
    end
  end

  // Reset discards any uncommitted store and clears the whole array.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      state     <= state_next;
      req_q     <= req_next;
      req_ready <= ready_next;
      rsp_valid <= valid_next;
      rsp_rdata <= rdata_next;
      rsp_err   <= err_next;
      if (mem_we) begin
        mem[cur_idx] <= mem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: instance 0 (DEPTH=256, LATENCY=2), instance 1 (DEPTH=16, LATENCY=0).
// A transaction-level model is compared every cycle; directed literals pin the model.
module tb_data_memory_responder;

  localparam int unsigned DEPTH_K [2] = '{256, 16};
  localparam int unsigned LAT_K   [2] = '{2, 0};

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH(256), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
`ifdef DMEM_BYTE_LANES_EN
    .req_be(req_be[0]),
`endif
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_memory_responder #(.DEPTH(16), .LATENCY(0)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
`ifdef DMEM_BYTE_LANES_EN
    .req_be(req_be[1]),
`endif
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: accept time, due edge of the response, word arrays.
  int unsigned cyc = 0;
  bit          m_live = 1'b0;
  bit          m_busy  [2];
  bit          m_valid [2];
  logic [31:0] m_rdata [2];
  bit          m_err   [2];
  int unsigned m_due   [2];
  bit          p_write [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wdata [2];
  logic [3:0]  p_be    [2];
  logic [31:0] m_mem   [2][256];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k] = 0; m_valid[k] = 0; m_rdata[k] = 0; m_err[k] = 0;
        for (int i = 0; i < 256; i++) m_mem[k][i] = 0;
      end else if (m_valid[k]) begin
        if (rsp_ready[k]) begin
          m_valid[k] = 0; m_rdata[k] = 0; m_err[k] = 0; m_busy[k] = 0;
        end
      end else begin
        if (!m_busy[k] && req_valid[k]) begin
          m_busy[k]  = 1;
          p_write[k] = req_write[k];
          p_addr[k]  = req_addr[k];
          p_wdata[k] = req_wdata[k];
          p_be[k]    = req_be[k];
          m_due[k]   = (LAT_K[k] == 0) ? cyc : cyc + LAT_K[k] + 1;
        end
        if (m_busy[k] && cyc == m_due[k]) begin
          logic [31:0] mask, idx;
          bit err;
          idx  = p_addr[k] / 4;
          err  = (p_addr[k] % 4 != 0) || (idx >= DEPTH_K[k]);
          mask = 32'hFFFF_FFFF;
`ifdef DMEM_BYTE_LANES_EN
          for (int b = 0; b < 4; b++) mask[8*b +: 8] = p_be[k][b] ? 8'hFF : 8'h00;
`endif
          m_valid[k] = 1;
          m_err[k]   = err;
          m_rdata[k] = 0;
          if (!err) begin
            if (p_write[k]) m_mem[k][idx] = (m_mem[k][idx] & ~mask) | (p_wdata[k] & mask);
            else            m_rdata[k] = m_mem[k][idx];
          end
        end
      end
    end
    if (reset) m_live = 1;
    cyc++;
  end

  always @(negedge clk) begin
    if (m_live) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("k%0d_rsp_valid", k), 32'(rsp_valid[k]), 32'(m_valid[k]));
        check($sformatf("k%0d_req_ready", k), 32'(req_ready[k]), 32'(!m_busy[k]));
        check($sformatf("k%0d_rsp_rdata", k), rsp_rdata[k], m_rdata[k]);
        check($sformatf("k%0d_rsp_err", k), 32'(rsp_err[k]), 32'(m_err[k]));
      end
    end
  end

  // Present a request and hold it until accepted; returns #1 after the accept edge.
  task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    bit ok = 0;
    req_write[k] = w; req_addr[k] = a; req_wdata[k] = d; req_be[k] = be; req_valid[k] = 1;
    for (int i = 0; i < 30 && !ok; i++) begin
      ok = req_ready[k];
      @(posedge clk); #1;
    end
    req_valid[k] = 0;
    check($sformatf("k%0d_accept_in_time", k), 32'(ok), 32'd1);
  endtask

  // Full transaction with rsp_ready high: edges from accept to rsp_valid, and busy cycles.
  task automatic do_req(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat, output int busy);
    bit seen = 0, back = 0;
    issue(k, w, a, d, be);
    lat = -1; busy = 0; rd = 'x; er = 'x;
    for (int i = 0; i < 40 && !back; i++) begin
      if (rsp_valid[k] && !seen) begin seen = 1; lat = i; rd = rsp_rdata[k]; er = rsp_err[k]; end
      if (req_ready[k]) back = 1;
      else begin busy++; @(posedge clk); #1; end
    end
    check($sformatf("k%0d_done_in_time", k), 32'(back && seen), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, busy;

  initial begin
    reset = 1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 0; req_write[k] = 0; req_addr[k] = 0; req_wdata[k] = 0;
      req_be[k] = 4'hF; rsp_ready[k] = 1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready[0]), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("reset_rsp_rdata", rsp_rdata[0], 32'd0);
    reset = 0;

    // Basic load timing.
    do_req(0, 0, 32'h10, 0, 4'hF, rd, er, lat, busy);
    check("t1_latency", 32'(lat), 32'd3);
    check("t1_busy_cycles", 32'(busy), 32'd4);
    check("t1_rdata", rd, 32'd0);
    check("t1_err", 32'(er), 32'd0);

    // Store then load the same word.
    do_req(0, 1, 32'h40, 32'hDEADBEEF, 4'hF, rd, er, lat, busy);
    check("t2_store_rdata", rd, 32'd0);
    check("t2_store_err", 32'(er), 32'd0);
    do_req(0, 0, 32'h40, 0, 4'hF, rd, er, lat, busy);
    check("t2_load_rdata", rd, 32'hDEADBEEF);

    // Misaligned and out-of-range accesses; no aliasing.
    do_req(0, 0, 32'h42, 0, 4'hF, rd, er, lat, busy);
    check("t3_misaligned_err", 32'(er), 32'd1);
    check("t3_misaligned_rdata", rd, 32'd0);
    do_req(0, 1, 32'h400, 32'hCAFEF00D, 4'hF, rd, er, lat, busy);
    check("t3_oor_store_err", 32'(er), 32'd1);
    do_req(0, 0, 32'h0, 0, 4'hF, rd, er, lat, busy);
    check("t3_no_alias_word0", rd, 32'd0);
    do_req(0, 0, 32'h3FC, 0, 4'hF, rd, er, lat, busy);
    check("t3_last_word", rd, 32'd0);
    check("t3_last_word_err", 32'(er), 32'd0);
    do_req(0, 0, 32'hFFFF_FFFC, 0, 4'hF, rd, er, lat, busy);
    check("t3_top_addr_err", 32'(er), 32'd1);

    // Back-pressure on the response; requests during RESP are ignored.
    rsp_ready[0] = 0;
    issue(0, 0, 32'h40, 0, 4'hF);
    for (int i = 0; i < 10 && !rsp_valid[0]; i++) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      req_valid[0] = (i % 2 == 0); req_write[0] = 1; req_addr[0] = 32'h0; req_wdata[0] = 32'h55;
      @(posedge clk); #1;
      check("t4_hold_valid", 32'(rsp_valid[0]), 32'd1);
      check("t4_hold_rdata", rsp_rdata[0], 32'hDEADBEEF);
      check("t4_hold_not_ready", 32'(req_ready[0]), 32'd0);
    end
    req_valid[0] = 0;
    rsp_ready[0] = 1;
    @(posedge clk); #1;
    check("t4_released", 32'(rsp_valid[0]), 32'd0);
    do_req(0, 0, 32'h0, 0, 4'hF, rd, er, lat, busy);
    check("t4_ignored_store", rd, 32'd0);

    // Reset during the wait of a store.
    issue(0, 1, 32'h8, 32'h12345678, 4'hF);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("t5_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("t5_req_ready", 32'(req_ready[0]), 32'd1);
    check("t5_rdata", rsp_rdata[0], 32'd0);
    repeat (4) @(posedge clk);
    #1;
    do_req(0, 0, 32'h8, 0, 4'hF, rd, er, lat, busy);
    check("t5_store_discarded", rd, 32'd0);

    // Zero-latency instance.
`ifdef DMEM_BYTE_LANES_EN
    do_req(1, 1, 32'h0, 32'hFFFFFFFF, 4'b1111, rd, er, lat, busy);
    check("t6_store_latency", 32'(lat), 32'd0);
    do_req(1, 1, 32'h0, 32'h00AA0000, 4'b0100, rd, er, lat, busy);
    do_req(1, 1, 32'h0, 32'h12345678, 4'b0000, rd, er, lat, busy);
    check("t6_noop_err", 32'(er), 32'd0);
    do_req(1, 0, 32'h0, 0, 4'hF, rd, er, lat, busy);
    check("t6_lanes_rdata", rd, 32'hFFAAFFFF);
    check("t6_load_latency", 32'(lat), 32'd0);
`else
    do_req(1, 1, 32'h4, 32'h11223344, 4'hF, rd, er, lat, busy);
    check("t6_store_latency", 32'(lat), 32'd0);
    check("t6_store_busy", 32'(busy), 32'd1);
    do_req(1, 0, 32'h4, 0, 4'hF, rd, er, lat, busy);
    check("t6_load_rdata", rd, 32'h11223344);
    check("t6_load_latency", 32'(lat), 32'd0);
`endif
    do_req(1, 0, 32'h40, 0, 4'hF, rd, er, lat, busy);
    check("t6_oor_err", 32'(er), 32'd1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
